// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: back-buffer write port and frame swap handshake
interface led_matrix_scanner_if;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_done;

    modport master (output wr_en, wr_row, wr_data, swap_req, input swap_done);
    modport slave  (input wr_en, wr_row, wr_data, swap_req, output swap_done);
endinterface

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered 8x8 LED row-scan refresh engine with inter-row blanking
module led_matrix_scanner #(
    parameter int ROW_PERIOD   = 6250,
    parameter int BLANK_CYCLES = 250
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    led_matrix_scanner_if.slave  bus,
    output logic                 o_frame_start,
    output logic [7:0]           o_rows,
    output logic [7:0]           o_cols
);
    localparam int CW = $clog2(ROW_PERIOD);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0] r_row;
    logic       r_front;
    logic       r_pending;
    logic [7:0] r_buf [0:1][0:7];
    logic       w_slot_end;
    logic       w_swap;

    assign w_slot_end = r_cnt == CW'(ROW_PERIOD - 1);
    assign w_swap     = w_slot_end && r_row == 3'd7 && (r_pending || bus.swap_req);

    // Blank at the start of each row slot, drive for the rest of it
    always_comb begin
        w_state_nxt = w_slot_end ? BLANK : (r_cnt == CW'(BLANK_CYCLES - 1)) ? DRIVE : r_state;
    end

    // State register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= BLANK;
        else            r_state <= w_state_nxt;
    end

    // Slot counter and row index; row wraps 7->0 naturally in 3 bits
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
            r_row <= '0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            r_row <= w_slot_end ? r_row + 3'd1 : r_row;
        end
    end

    // Swap bookkeeping: requests latch until the frame wrap, then flip the front buffer
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_front   <= 1'b0;
            r_pending <= 1'b0;
        end else if (w_swap) begin
            r_front   <= ~r_front;
            r_pending <= 1'b0;
        end else if (bus.swap_req) begin
            r_pending <= 1'b1;
        end
    end

    // Writes target the back buffer as selected before any swap in this cycle
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 8; j++)
                    r_buf[i][j] <= '0;
        end else if (bus.wr_en) begin
            r_buf[~r_front][bus.wr_row] <= bus.wr_data;
        end
    end

    // Registered outputs, one cycle behind state and counter
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rows        <= '0;
            o_cols        <= '0;
            o_frame_start <= 1'b0;
            bus.swap_done <= 1'b0;
        end else begin
            o_rows        <= (r_state == DRIVE) ? 8'd1 << r_row : 8'd0;
            o_cols        <= (r_state == DRIVE) ? r_buf[r_front][r_row] : 8'd0;
            o_frame_start <= r_cnt == '0 && r_row == 3'd0;
            bus.swap_done <= w_swap;
        end
    end
endmodule
